status_reader: RTL and testbench
================================

STATUS_READER -- requirements
Module: status_reader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4 (min 2): clock cycles each serial bit is held on tx.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 fgt1, frt1, fgc1, frc1, fgt2, frt2, fgc2, frc2  input  5 each  fridge status values.
REQ-005 actemp1, accap1, acfan1, actimer1, actemp2, accap2, acfan2, actimer2  input  5 each  AC status values.
REQ-006 req  input  1  single-read request, sampled only in IDLE.
REQ-007 req_addr  input  4  register select for req.
REQ-008 scan  input  1  request a full sweep of all 16 registers, sampled only in IDLE.
REQ-009 tx  output  1  serial frame line, idle high.
REQ-010 busy  output  1  high while a frame or sweep is in progress.
REQ-011 done  output  1  one-cycle pulse when a single read or a whole sweep completes.

Function
REQ-012 Address map SHALL be: addr[3]=0 fridge, 1 AC; addr[2]=0 unit 1, 1 unit 2; addr[1:0] for fridge 0 fgt, 1 frt, 2 fgc, 3 frc; for AC 0 temp, 1 cap, 2 fan, 3 timer (0-3 fridge1, 4-7 fridge2, 8-11 ac1, 12-15 ac2).
REQ-013 FSM states SHALL be IDLE, SEND, NEXT.
REQ-014 IDLE: tx=1, busy=0; req or scan high at an edge SHALL move to SEND.
REQ-015 req and scan high together in IDLE: scan SHALL win; req is dropped.
REQ-016 req or scan while busy=1 SHALL be ignored, not queued.
REQ-017 On the accepting edge, addr and the selected 5-bit value SHALL be loaded into a frame shift register; later status changes SHALL not alter that frame.
REQ-018 Frame, LSB first within fields: start 0, addr[3:0], data[4:0], optional parity (REQ-026), stop 1.
REQ-019 tx SHALL show the start bit from the cycle after acceptance; each bit held exactly CLKS_PER_BIT cycles.
REQ-020 busy SHALL rise the cycle after acceptance and stay high until the final stop bit ends.
REQ-021 Single read: after stop bit, return to IDLE; done=1 for exactly that cycle.
REQ-022 Sweep: addresses 0..15 in order; between frames one NEXT cycle (tx=1, busy=1), in which the next address and value are loaded.
REQ-023 Sweep address counter SHALL not wrap past 15; after frame 15 go IDLE with one done pulse (no done between frames).
REQ-024 Bit counter and baud counter SHALL reset to 0 at each frame start.

Reset
REQ-025 rst_n low, including mid-frame or mid-sweep: state=IDLE, tx=1, busy=0, done=0, counters and shift register 0, within the same cycle; no partial frame resumes after release.

Configuration
REQ-026 Macro STATUS_PARITY_EN: when defined, an even-parity bit over addr[3:0] and data[4:0] SHALL be sent between data and stop (12-bit frame); when undefined no parity bit (11-bit frame).

Verification (CLKS_PER_BIT=4)
REQ-027 Parity on, frt2=5'b10110, req with req_addr=5 -> tx bits 0,1,0,1,0,0,1,1,0,1,1,1 each 4 cycles, busy high 48 cycles, then done pulse.
REQ-028 Parity off, same stimulus -> 11 bits (no parity), busy high 44 cycles.
REQ-029 scan with acfan2=5'b11111, other inputs 0 -> 16 frames, addr 0..15 in order, each frame separated by one tx=1 cycle, frame 14 data 11111, exactly one done after frame 15.
REQ-030 req and scan asserted same cycle -> full sweep; second req during busy -> no extra frame.
REQ-031 Change fgt1 from 3 to 7 during frame for addr 0 -> frame carries 3.
REQ-032 rst_n low at bit 6 of a sweep frame -> tx=1, busy=0 immediately; after release, nothing until new req.

Source files
------------

// File: rtl/status_reader.sv
// Serialises fridge/AC status registers as start/addr/data/[parity]/stop frames on tx.
// Define STATUS_PARITY_EN to append an even-parity bit over addr and data (12-bit frame).
module status_reader #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] fgt1,
    input  logic [4:0] frt1,
    input  logic [4:0] fgc1,
    input  logic [4:0] frc1,
    input  logic [4:0] fgt2,
    input  logic [4:0] frt2,
    input  logic [4:0] fgc2,
    input  logic [4:0] frc2,
    input  logic [4:0] actemp1,
    input  logic [4:0] accap1,
    input  logic [4:0] acfan1,
    input  logic [4:0] actimer1,
    input  logic [4:0] actemp2,
    input  logic [4:0] accap2,
    input  logic [4:0] acfan2,
    input  logic [4:0] actimer2,
    input  logic       req,
    input  logic [3:0] req_addr,
    input  logic       scan,
    output logic       tx,
    output logic       busy,
    output logic       done
);

`ifdef STATUS_PARITY_EN
    localparam int unsigned FRAME_BITS = 12;
`else
    localparam int unsigned FRAME_BITS = 11;
`endif
    localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {StIdle, StSend, StNext} state_e;

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   sreg_q;
    logic [BW-1:0]           baud_q;
    logic [3:0]              bit_q;
    logic [3:0]              addr_q;
    logic                    sweep_q;
    logic                    done_q;

    logic                    accept, bit_end, frame_end, last_frame;
    logic [3:0]              load_addr;
    logic [4:0]              sel_data;
    logic [FRAME_BITS-1:0]   frame;

    assign accept     = (state_q == StIdle) && (req || scan);
    assign bit_end    = (baud_q == BAUD_LAST);
    assign frame_end  = (state_q == StSend) && bit_end && (bit_q == BIT_LAST);
    assign last_frame = !sweep_q || (addr_q == 4'd15);
    // In IDLE the new frame's address comes from the request; in NEXT it is the sweep successor.
    assign load_addr  = (state_q == StIdle) ? (scan ? 4'd0 : req_addr) : (addr_q + 4'd1);

    always_comb begin
        sel_data = 5'd0;
        unique case (load_addr)
            4'd0:  sel_data = fgt1;
            4'd1:  sel_data = frt1;
            4'd2:  sel_data = fgc1;
            4'd3:  sel_data = frc1;
            4'd4:  sel_data = fgt2;
            4'd5:  sel_data = frt2;
            4'd6:  sel_data = fgc2;
            4'd7:  sel_data = frc2;
            4'd8:  sel_data = actemp1;
            4'd9:  sel_data = accap1;
            4'd10: sel_data = acfan1;
            4'd11: sel_data = actimer1;
            4'd12: sel_data = actemp2;
            4'd13: sel_data = accap2;
            4'd14: sel_data = acfan2;
            4'd15: sel_data = actimer2;
        endcase
    end

`ifdef STATUS_PARITY_EN
    assign frame = {1'b1, ^{load_addr, sel_data}, sel_data, load_addr, 1'b0};
`else
    assign frame = {1'b1, sel_data, load_addr, 1'b0};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req || scan) state_d = StSend;
            StSend: if (frame_end) state_d = last_frame ? StIdle : StNext;
            StNext: state_d = StSend;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx   = (state_q == StSend) ? sreg_q[0] : 1'b1;
        busy = (state_q != StIdle);
        done = done_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q  <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            addr_q  <= '0;
            sweep_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= frame_end && last_frame;
            if (accept || state_q == StNext) begin
                sreg_q <= frame;
                addr_q <= load_addr;
                baud_q <= '0;
                bit_q  <= '0;
                if (accept) sweep_q <= scan;
            end else if (state_q == StSend) begin
                if (bit_end) begin
                    baud_q <= '0;
                    bit_q  <= bit_q + 4'd1;
                    sreg_q <= {1'b1, sreg_q[FRAME_BITS-1:1]};
                end else begin
                    baud_q <= baud_q + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_status_reader.sv
// Directed bench for status_reader: table of single reads plus sweep, collision,
// snapshot and mid-frame reset sequences.
module tb_status_reader;

    localparam int CPB = 4;
`ifdef STATUS_PARITY_EN
    localparam int FB = 12;
`else
    localparam int FB = 11;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] regs [16];
    logic       req, scan;
    logic [3:0] req_addr;
    logic       tx, busy, done;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] addr;
        logic [4:0] data;
        logic       par;   // hand-computed even parity over addr and data
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    status_reader #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n),
        .fgt1(regs[0]), .frt1(regs[1]), .fgc1(regs[2]), .frc1(regs[3]),
        .fgt2(regs[4]), .frt2(regs[5]), .fgc2(regs[6]), .frc2(regs[7]),
        .actemp1(regs[8]), .accap1(regs[9]), .acfan1(regs[10]), .actimer1(regs[11]),
        .actemp2(regs[12]), .accap2(regs[13]), .acfan2(regs[14]), .actimer2(regs[15]),
        .req(req), .req_addr(req_addr), .scan(scan),
        .tx(tx), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] mk_bits(input logic [3:0] a, input logic [4:0] d,
                                            input logic p);
        logic [11:0] b;
        b = 12'hFFF;
        b[0] = 1'b0;
        b[4:1] = a;
        b[9:5] = d;
        b[10] = (FB == 12) ? p : 1'b1;
        return b;
    endfunction

    task automatic background();
        for (int i = 0; i < 16; i++) regs[i] = 5'(i) ^ 5'h15;
    endtask

    // Entered at the first negedge of the frame; leaves at the negedge after its last cycle.
    task automatic check_frame(input logic [3:0] a, input logic [4:0] d, input logic p);
        logic [11:0] b;
        b = mk_bits(a, d, p);
        for (int k = 0; k < FB * CPB; k++) begin
            chk($sformatf("tx a%0d bit%0d", a, k / CPB), tx, b[k / CPB]);
            chk("busy in frame", busy, 1'b1);
            chk("done in frame", done, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic check_end();
        chk("busy after end", busy, 1'b0);
        chk("done pulse", done, 1'b1);
        chk("tx idle at end", tx, 1'b1);
        @(negedge clk);
        chk("done single cycle", done, 1'b0);
    endtask

    task automatic check_sweep(input logic [4:0] snap [16]);
        for (int a = 0; a < 16; a++) begin
            check_frame(4'(a), snap[a], ^{4'(a), snap[a]});
            if (a < 15) begin
                chk("next tx high", tx, 1'b1);
                chk("next busy", busy, 1'b1);
                chk("no done between frames", done, 1'b0);
                @(negedge clk);
            end
        end
        check_end();
    endtask

    task automatic check_quiet(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk("quiet tx", tx, 1'b1);
            chk("quiet busy", busy, 1'b0);
            chk("quiet done", done, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic single_read(input logic [3:0] a);
        req = 1'b1;
        req_addr = a;
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        logic [4:0] snap [16];
        vecs[0] = '{4'd5,  5'b10110, 1'b1};
        vecs[1] = '{4'd0,  5'b00000, 1'b0};
        vecs[2] = '{4'd15, 5'b11111, 1'b1};
        vecs[3] = '{4'd10, 5'b00001, 1'b1};
        vecs[4] = '{4'd3,  5'b10100, 1'b0};
        vecs[5] = '{4'd12, 5'b01100, 1'b0};
        vecs[6] = '{4'd6,  5'b11000, 1'b0};
        vecs[7] = '{4'd9,  5'b00111, 1'b1};

        rst_n = 1'b0; req = 1'b0; scan = 1'b0; req_addr = 4'd0;
        background();
        #1;
        chk("reset tx", tx, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single reads from the table
        foreach (vecs[i]) begin
            background();
            regs[vecs[i].addr] = vecs[i].data;
            single_read(vecs[i].addr);
            check_frame(vecs[i].addr, vecs[i].data, vecs[i].par);
            check_end();
            check_quiet(2);
        end

        // Full sweep: only acfan2 non-zero
        for (int i = 0; i < 16; i++) regs[i] = 5'd0;
        regs[14] = 5'b11111;
        snap = regs;
        scan = 1'b1;
        @(negedge clk);
        scan = 1'b0;
        check_sweep(snap);
        check_quiet(3);

        // req and scan together: scan wins; a req during busy is dropped
        background();
        snap = regs;
        req = 1'b1; scan = 1'b1; req_addr = 4'd9;
        @(negedge clk);
        req = 1'b0; scan = 1'b0;
        fork
            begin
                repeat (30) @(negedge clk);
                req = 1'b1; req_addr = 4'd7;
                @(negedge clk);
                req = 1'b0;
            end
        join_none
        check_sweep(snap);
        check_quiet(10);

        // Value change mid-frame must not alter the captured frame
        background();
        regs[0] = 5'd3;
        single_read(4'd0);
        fork
            begin
                repeat (10) @(negedge clk);
                regs[0] = 5'd7;
            end
        join_none
        check_frame(4'd0, 5'd3, 1'b0);
        check_end();
        check_quiet(2);

        // Reset during bit 6 of a sweep frame
        background();
        scan = 1'b1;
        @(negedge clk);
        scan = 1'b0;
        repeat (6 * CPB + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset tx", tx, 1'b1);
        chk("mid reset busy", busy, 1'b0);
        chk("mid reset done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_quiet(20);

        // New request still works after reset
        background();
        regs[vecs[0].addr] = vecs[0].data;
        single_read(vecs[0].addr);
        check_frame(vecs[0].addr, vecs[0].data, vecs[0].par);
        check_end();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
